chunked_add_sub: RTL and testbench

//  Parametrised multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per

---
 rtl/chunked_add_sub.sv | 116 +++++++++++
 tb/tb_chunked_add_sub.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle chunked adder/subtractor with valid/ready handshakes
// Operands are summed CHUNK bits per clock, LSB chunk first, with the carry held in a register.
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_ch;
  logic             msb_cin;

  assign a_ch = a_q[cnt_q*CHUNK +: CHUNK];
  assign b_ch = b_q[cnt_q*CHUNK +: CHUNK];
  assign {c_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the MSB recovered from the MSB sum bit, valid for any CHUNK including 1.
  assign msb_cin = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[cnt_q*CHUNK +: CHUNK] = s_ch;
        carry_d = c_ch;
        if (cnt_q == LAST_CHUNK) begin
          cout_d  = c_ch;
          ovf_d   = msb_cin ^ c_ch;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// tb/tb_chunked_add_sub.sv - scoreboard bench for chunked_add_sub at CHUNK=4, 16 and 1
// Instance k: 0 -> CHUNK=4, 1 -> CHUNK=16, 2 -> CHUNK=1 (all WIDTH=16).
module tb_chunked_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic [2:0]       in_valid_r, cin_r, sub_r, out_ready_r;
  logic [2:0][15:0] a_r, b_r;
  wire  [2:0]       in_ready_w, out_valid_w, cout_w, ovf_w;
  wire  [2:0][15:0] sum_w;

  int cmp_count  = 0;
  int fail_count = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t sb_q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    chunked_add_sub #(.WIDTH(16), .CHUNK((g == 0) ? 4 : ((g == 1) ? 16 : 1))) u_dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .in_valid (in_valid_r[g]),
      .in_ready (in_ready_w[g]),
      .a        (a_r[g]),
      .b        (b_r[g]),
      .cin      (cin_r[g]),
      .sub      (sub_r[g]),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready_r[g]),
      .sum      (sum_w[g]),
      .cout     (cout_w[g]),
      .ovf      (ovf_w[g])
    );
  end

  function automatic res_t ref_model(input logic [15:0] x, input logic [15:0] y,
                                     input logic ci, input logic s);
    logic [15:0] yy;
    logic [16:0] full;
    res_t        r;
    yy     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : ci)};
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (x[15] == yy[15]) && (r.sum[15] != x[15]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int k, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic s, input int hold);
    res_t e;
    int   lat;
    int   nch;
    nch = (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    @(negedge clk);
    lat = 0;
    while (!in_ready_w[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("in_ready_idle", {31'd0, in_ready_w[k]}, 32'd1);
    in_valid_r[k]  = 1'b1;
    a_r[k]         = x;
    b_r[k]         = y;
    cin_r[k]       = ci;
    sub_r[k]       = s;
    out_ready_r[k] = (hold == 0);
    sb_q.push_back(ref_model(x, y, ci, s));
    @(posedge clk);
    #1;
    // Scramble operands after accept; they must not affect the result.
    in_valid_r[k] = 1'b0;
    a_r[k]        = 16'($urandom);
    b_r[k]        = 16'($urandom);
    cin_r[k]      = ~ci;
    sub_r[k]      = ~s;
    lat = 0;
    while (!out_valid_w[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, nch);
    e = sb_q.pop_front();
    check("sum", {16'd0, sum_w[k]}, {16'd0, e.sum});
    check("cout", {31'd0, cout_w[k]}, {31'd0, e.cout});
    check("ovf", {31'd0, ovf_w[k]}, {31'd0, e.ovf});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid_r[k] = i[0];
      a_r[k]        = 16'($urandom);
      @(posedge clk);
      #1;
      check("hold_out_valid", {31'd0, out_valid_w[k]}, 32'd1);
      check("hold_sum", {16'd0, sum_w[k]}, {16'd0, e.sum});
      check("hold_in_ready", {31'd0, in_ready_w[k]}, 32'd0);
    end
    @(negedge clk);
    out_ready_r[k] = 1'b1;
    in_valid_r[k]  = 1'b0;
    @(posedge clk);
    #1;
    check("post_out_valid", {31'd0, out_valid_w[k]}, 32'd0);
    check("post_in_ready", {31'd0, in_ready_w[k]}, 32'd1);
  endtask

  initial begin
    resetn      = 1'b0;
    in_valid_r  = '0;
    cin_r       = '0;
    sub_r       = '0;
    out_ready_r = '1;
    a_r         = '0;
    b_r         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {29'd0, out_valid_w}, 32'd0);
    check("rst_in_ready", {29'd0, in_ready_w}, 32'd7);
    check("rst_sum", {16'd0, sum_w[0]}, 32'd0);
    check("rst_cout", {29'd0, cout_w}, 32'd0);
    check("rst_ovf", {29'd0, ovf_w}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(0, 16'h1234, 16'h4321, 1'b1, 1'b0, 0);
    do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    do_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b1, 10);

    // Abort an operation two cycles after accept with an asynchronous reset.
    @(negedge clk);
    in_valid_r[0] = 1'b1;
    a_r[0]        = 16'h1111;
    b_r[0]        = 16'h1111;
    cin_r[0]      = 1'b0;
    sub_r[0]      = 1'b0;
    @(posedge clk);
    #1;
    in_valid_r[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid_w[0]}, 32'd0);
    check("abort_sum", {16'd0, sum_w[0]}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    do_op(0, 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 0);

    do_op(1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 0);
    do_op(2, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 0);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        do_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
